// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
// Instruction fetch sequencer sitting between PC/redirect logic and a
// synchronous instruction memory with one cycle of read latency. It owns the
// program counter, drives the memory address every cycle, and hands
// (instruction, pc) pairs to decode over a valid/ready handshake. A one-entry
// skid buffer absorbs decode back-pressure so that out_ready never reaches
// mem_addr combinationally.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   enable         1 = issue new fetches, 0 = freeze issue (buffered data drains)
//   redirect_valid flush everything and restart fetch at redirect_pc
//   redirect_pc    restart address, bits [1:0] ignored
//   mem_addr       instruction memory address
//   mem_data       instruction memory read data (address of previous edge)
//   out_valid      instruction available to decode
//   out_ready      decode accepts this cycle
//   out_instr      instruction word
//   out_pc         address of out_instr
// -----------------------------------------------------------------------------
module instr_fetch_ctrl #(
    parameter int unsigned          WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic [WORD_SIZE-1:0] mem_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_instr,
    output logic [WORD_SIZE-1:0] out_pc
);

    localparam logic [WORD_SIZE-1:0] PC_STEP = {{(WORD_SIZE-3){1'b0}}, 3'b100};

    logic [WORD_SIZE-1:0] fetch_pc_r;   // next address to issue
    logic                 inf_v_r;      // request whose data is on mem_data now
    logic [WORD_SIZE-1:0] inf_pc_r;
    logic                 sk_v_r;       // skid entry (older than the in-flight one)
    logic [WORD_SIZE-1:0] sk_instr_r;
    logic [WORD_SIZE-1:0] sk_pc_r;

    logic                 issue_s;
    logic                 fire_s;

    // Output selection, handshake and memory address steering.
    always_comb begin
        out_valid = 1'b0;
        out_instr = mem_data;
        out_pc    = inf_pc_r;
        issue_s   = 1'b0;
        fire_s    = 1'b0;
        mem_addr  = fetch_pc_r;

        // The skid entry is always the oldest pending instruction.
        if (sk_v_r) begin
            out_instr = sk_instr_r;
            out_pc    = sk_pc_r;
        end else begin
            out_instr = mem_data;
            out_pc    = inf_pc_r;
        end

        out_valid = (sk_v_r | inf_v_r) & ~redirect_valid;
        fire_s    = out_valid & out_ready;

        // Issue depends only on enable, skid occupancy and redirect, never on
        // out_ready, which keeps decode back-pressure off the address path.
        issue_s = enable & ~sk_v_r & ~redirect_valid;

        // Without a new issue the in-flight address is replayed so mem_data
        // keeps presenting the same word next cycle.
        if (inf_v_r && !issue_s) begin
            mem_addr = inf_pc_r;
        end else begin
            mem_addr = fetch_pc_r;
        end
    end

    // PC, in-flight and skid state: redirect beats issue beats hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r <= RESET_PC;
            inf_v_r    <= 1'b0;
            inf_pc_r   <= '0;
            sk_v_r     <= 1'b0;
            sk_instr_r <= '0;
            sk_pc_r    <= '0;
        end else if (redirect_valid) begin
            fetch_pc_r <= {redirect_pc[WORD_SIZE-1:2], 2'b00};
            inf_v_r    <= 1'b0;
            sk_v_r     <= 1'b0;
        end else if (issue_s) begin
            inf_pc_r   <= fetch_pc_r;
            fetch_pc_r <= fetch_pc_r + PC_STEP;
            inf_v_r    <= 1'b1;
            // The word on mem_data is about to be overwritten; park it if
            // decode is not taking it this cycle (ONE -> FULL).
            if (inf_v_r && !fire_s) begin
                sk_v_r     <= 1'b1;
                sk_instr_r <= mem_data;
                sk_pc_r    <= inf_pc_r;
            end else begin
                sk_v_r     <= sk_v_r;
            end
        end else if (sk_v_r) begin
            // FULL: draining the skid leaves the replayed in-flight word.
            if (fire_s) begin
                sk_v_r <= 1'b0;
            end else begin
                sk_v_r <= sk_v_r;
            end
        end else if (inf_v_r) begin
            // ONE with issue frozen: the last word leaves and we go EMPTY.
            if (fire_s) begin
                inf_v_r <= 1'b0;
            end else begin
                inf_v_r <= inf_v_r;
            end
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

endmodule
